// File: rtl/async_fifo_rd_streamer_if.sv
// FIFO read port plus downstream valid/ready stream for the read-side streamer.
// Latency: none (signal bundle only).
// Backpressure: m_ready from the sink; rempty from the FIFO.
interface async_fifo_rd_streamer_if #(
    parameter int DSIZE = 8
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
`ifdef FIFO_RD_PARITY_EN
    logic             m_parity;
`endif

    // Streamer side: consumes the FIFO, sources the stream
    modport master (
        input  rempty,
        input  rdata,
        input  m_ready,
        output rinc,
        output m_data,
`ifdef FIFO_RD_PARITY_EN
        output m_parity,
`endif
        output m_valid
    );

    // FIFO / sink side
    modport slave (
        output rempty,
        output rdata,
        output m_ready,
        input  rinc,
        input  m_data,
`ifdef FIFO_RD_PARITY_EN
        input  m_parity,
`endif
        input  m_valid
    );
endinterface

// File: rtl/async_fifo_rd_streamer.sv
// Pops bursts from an FWFT async FIFO read port into a 2-entry buffer feeding a valid/ready stream.
// Latency: word popped at edge N is on m_data with m_valid=1 right after edge N; 1 word/cycle sustained.
// Backpressure: pops stop once the buffer holds 2 words; rinc has no combinational path from m_ready.
// Optional feature macro: FIFO_RD_PARITY_EN adds m_parity (XOR of the stored word) to the stream.
module async_fifo_rd_streamer #(
    parameter int DSIZE   = 8,
    parameter int BURST_W = 8
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     start,
    input  logic [BURST_W-1:0]       burst_len,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              pop_count,
    async_fifo_rd_streamer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One buffer entry: the word plus, when enabled, its parity captured at pop time
    typedef struct packed {
`ifdef FIFO_RD_PARITY_EN
        logic             par;
`endif
        logic [DSIZE-1:0] data;
    } entry_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               fixed_q, fixed_d;
    logic [1:0]         occ_q, occ_d;
    entry_t             buf0_q, buf0_d;
    entry_t             buf1_q, buf1_d;
    logic [15:0]        pop_count_q, pop_count_d;

    logic               pop;
    logic               xfer;
    entry_t             new_entry;

    assign xfer = (occ_q != 2'd0) && bus.m_ready;

    // Entry built from the FIFO head word
    always_comb begin
        new_entry      = '0;
        new_entry.data = bus.rdata;
`ifdef FIFO_RD_PARITY_EN
        new_entry.par  = ^bus.rdata;
`endif
    end

    // State register
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stop cycle or the final fixed-mode pop ends RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (fixed_q && pop && (remaining_q == BURST_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the buffer empties, including the accept of its last word
                if ((occ_q == 2'd0) || ((occ_q == 2'd1) && xfer)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; pop depends only on state, FIFO flag, occupancy and stop
    always_comb begin
        pop  = (state_q == RUN) && !bus.rempty && (occ_q < 2'd2) && !stop;
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Burst bookkeeping, buffer update and pop counter
    always_comb begin
        remaining_d = remaining_q;
        fixed_d     = fixed_q;
        occ_d       = occ_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        pop_count_d = pop_count_q;

        if ((state_q == IDLE) && start) begin
            remaining_d = burst_len;
            fixed_d     = (burst_len != '0);
        end else if (pop && fixed_q) begin
            remaining_d = remaining_q - BURST_W'(1);
        end

        if (pop) pop_count_d = pop_count_q + 16'd1;

        case ({pop, xfer})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = new_entry;
                else               buf1_d = new_entry;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // pop needs occ<2 and xfer needs occ>0, so exactly one entry is being replaced
                buf0_d = new_entry;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            remaining_q <= '0;
            fixed_q     <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            pop_count_q <= 16'd0;
        end else begin
            remaining_q <= remaining_d;
            fixed_q     <= fixed_d;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            pop_count_q <= pop_count_d;
        end
    end

    assign bus.rinc    = pop;
    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = buf0_q.data;
`ifdef FIFO_RD_PARITY_EN
    assign bus.m_parity = buf0_q.par;
`endif
    assign pop_count   = pop_count_q;

endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// Bench for async_fifo_rd_streamer: FWFT FIFO model feeding the DUT, stream sink logging accepted words.
// Table of burst scenarios with hand-computed pop/leftover counts plus hand sequences for reset and parity.
// Drives on the falling edge, samples on the falling edge.
module tb_async_fifo_rd_streamer;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        start;
    logic [7:0]  burst_len;
    logic        stop;
    logic        busy;
    logic        done;
    logic [15:0] pop_count;

    always #5 rclk = ~rclk;

    async_fifo_rd_streamer_if #(.DSIZE(8)) bus ();

    async_fifo_rd_streamer #(.DSIZE(8), .BURST_W(8)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .start     (start),
        .burst_len (burst_len),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .pop_count (pop_count),
        .bus       (bus)
    );

    // FWFT FIFO model: never reset by rrst_n
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       stall  = 1'b0;

    assign bus.rempty = stall || (rd_ptr == wr_ptr);
    assign bus.rdata  = mem[rd_ptr[5:0]];

    // Observers: pops, accepted words, done pulses
    int         pops   = 0;
    int         acc_n  = 0;
    int         done_n = 0;
    logic [7:0] acc_log [0:127];

    always @(posedge rclk) begin
        if (bus.rinc) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
        if (bus.m_valid && bus.m_ready) begin
            acc_log[acc_n[6:0]] <= bus.m_data;
            acc_n <= acc_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    int total = 0;
    int bad   = 0;
    int exp_pc = 0;
    logic [7:0] next_val = 8'h11;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic push(input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr[5:0]] = next_val;
            wr_ptr++;
            next_val = next_val + 8'h11;
        end
    endtask

    typedef struct {
        int blen;       // burst_len
        int nwords;     // words added to the FIFO before the burst
        int stop_at;    // assert stop once this many pops are seen (-1 = never)
        int ready_low;  // m_ready held low for this many cycles after start
        int stall_at;   // force rempty once this many pops are seen (0 = never)
        int stall_len;  // cycles of forced empty
        int exp_pops;
        int exp_left;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx, input vec_t v);
        int  pop_base, acc_base, done_base, rd_base, cyc, after_done, stall_cnt, stall_bad;
        bit  stopped, stalling, stall_done, finished;
        string tag;
        tag = $sformatf("v%0d", idx);
        push(v.nwords);
        @(negedge rclk);
        pop_base  = pops;
        acc_base  = acc_n;
        done_base = done_n;
        rd_base   = rd_ptr;
        start     = 1'b1;
        burst_len = 8'(v.blen);
        bus.m_ready = (v.ready_low == 0);
        cyc = 0; after_done = 0; stall_cnt = 0; stall_bad = 0;
        stopped = 0; stalling = 0; stall_done = 0; finished = 0;
        while (!finished && cyc < 300) begin
            @(negedge rclk);
            cyc++;
            // A second start while busy must be ignored
            start     = (cyc == 2) && busy;
            burst_len = start ? 8'd9 : 8'(v.blen);
            if (v.ready_low > 0 && cyc == v.ready_low) begin
                check({tag, "_bp_pops"}, 32'(pops - pop_base), 32'd2);
                check({tag, "_bp_hold"}, {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, mem[rd_base[5:0]]});
                bus.m_ready = 1'b1;
            end
            if (stalling) begin
                if (bus.rinc || !busy) stall_bad++;
                stall_cnt++;
                if (stall_cnt == v.stall_len) begin
                    stall    = 1'b0;
                    stalling = 0;
                end
            end else if (v.stall_at > 0 && !stall_done && (pops - pop_base) == v.stall_at) begin
                stall      = 1'b1;
                stalling   = 1;
                stall_done = 1;
            end
            stop = 1'b0;
            if (v.stop_at >= 0 && !stopped && (pops - pop_base) == v.stop_at) begin
                stop    = 1'b1;
                stopped = 1;
            end
            if (done_n > done_base) begin
                after_done++;
                if (after_done > 3) finished = 1;
            end
        end
        stop  = 1'b0;
        start = 1'b0;
        check({tag, "_timeout"}, 32'(finished), 32'd1);
        if (v.stall_at > 0) check({tag, "_stall"}, 32'(stall_bad), 32'd0);
        check({tag, "_pops"}, 32'(pops - pop_base), 32'(v.exp_pops));
        check({tag, "_acc"}, 32'(acc_n - acc_base), 32'(v.exp_pops));
        for (int i = 0; i < v.exp_pops; i++) begin
            int a, r;
            a = acc_base + i;
            r = rd_base + i;
            check($sformatf("%s_word%0d", tag, i), 32'(acc_log[a[6:0]]), 32'(mem[r[5:0]]));
        end
        check({tag, "_done"}, 32'(done_n - done_base), 32'd1);
        exp_pc += v.exp_pops;
        check({tag, "_pop_count"}, 32'(pop_count), 32'(exp_pc));
        check({tag, "_left"}, 32'(wr_ptr - rd_ptr), 32'(v.exp_left));
        check({tag, "_idle"}, {30'd0, busy, bus.m_valid}, 32'd0);
    endtask

    initial begin
        int pop_base, waited;
        //            blen nw stop rlow st_at st_len pops left
        vecs[0] = '{3, 0, -1, 0, 0, 0,  3, 0};  // resumes the burst cut by reset
        vecs[1] = '{4, 4, -1, 0, 0, 0,  4, 0};  // plain burst of 4
        vecs[2] = '{5, 5, -1, 6, 0, 0,  5, 0};  // backpressure
        vecs[3] = '{4, 4, -1, 0, 2, 10, 4, 0};  // empty stall after 2 words
        vecs[4] = '{0, 8, 6,  0, 0, 0,  6, 2};  // continuous, stop at 7th pop
        vecs[5] = '{2, 1, -1, 0, 0, 0,  2, 1};  // leftovers first, fixed 2
        vecs[6] = '{1, 0, -1, 0, 0, 0,  1, 0};  // single word

        rrst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        burst_len = 8'd0;
        bus.m_ready = 1'b1;
        #3;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_valid", 32'(bus.m_valid), 32'd0);
        check("rst_data",  32'(bus.m_data), 32'd0);
        check("rst_pc",    32'(pop_count), 32'd0);
        check("rst_rinc",  32'(bus.rinc), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Reset in the middle of a 5-word burst after 2 pops
        push(5);
        @(negedge rclk);
        pop_base  = pops;
        start     = 1'b1;
        burst_len = 8'd5;
        waited    = 0;
        do begin
            @(negedge rclk);
            start = 1'b0;
            waited++;
        end while ((pops - pop_base) < 2 && waited < 20);
        check("mid_pops", 32'(pops - pop_base), 32'd2);
        #2 rrst_n = 1'b0;
        #1;
        check("mid_rst_outs", {12'd0, busy, done, bus.m_valid, bus.rinc, pop_count},
              {12'd0, 4'd0, 16'd0});
        check("mid_rst_data", 32'(bus.m_data), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        exp_pc = 0;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

`ifdef FIFO_RD_PARITY_EN
        // Parity travels with each word
        mem[wr_ptr[5:0]] = 8'h03; wr_ptr++;
        mem[wr_ptr[5:0]] = 8'h07; wr_ptr++;
        @(negedge rclk);
        bus.m_ready = 1'b0;
        start = 1'b1;
        burst_len = 8'd2;
        @(negedge rclk);
        start = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        check("par_w0", {22'd0, bus.m_valid, bus.m_parity, bus.m_data}, {22'd0, 1'b1, 1'b0, 8'h03});
        bus.m_ready = 1'b1;
        @(negedge rclk);
        check("par_w1", {22'd0, bus.m_valid, bus.m_parity, bus.m_data}, {22'd0, 1'b1, 1'b1, 8'h07});
        repeat (4) @(negedge rclk);
        exp_pc += 2;
        check("par_pc", 32'(pop_count), 32'(exp_pc));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_streamer.md
Name: async_fifo_rd_streamer

Overview:
Read-side consumer for the async FIFO, running entirely in the read clock domain. It pops words from the FIFO read port (rdata/rinc/rempty) in software-controlled bursts. Popped words pass through a 2-entry output buffer and are presented on a valid/ready stream to downstream logic. It is the counterpart to the write-side producer and is used both in the datapath and as the bench's DUT-side drain.

Parameters:
DSIZE, 8, FIFO data width; matches the FIFO instance.
BURST_W, 8, width of burst_len.

Ports:
rclk  input  1  read clock; the only clock.
rrst_n  input  1  asynchronous active-low reset.
start  input  1  1-cycle request to begin a burst; sampled only in IDLE.
burst_len  input  BURST_W  words to pop; 0 = continuous until stop.
stop  input  1  ends a burst early; sampled in RUN.
busy  output  1  high whenever state != IDLE.
done  output  1  1-cycle pulse at burst completion.
rempty  input  1  FIFO empty flag.
rdata  input  DSIZE  FIFO head word; valid whenever rempty=0 (first-word fall-through).
rinc  output  1  FIFO pop; word is consumed at the rclk edge where rinc=1.
m_data  output  DSIZE  stream data (buffer head).
m_valid  output  1  stream valid.
m_ready  input  1  stream ready.
pop_count  output  16  total words popped since reset; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (asynchronous, rrst_n=0):
  - State = IDLE, buffer occupancy = 0, remaining = 0.
  - m_valid=0, m_data=0, done=0, busy=0, pop_count=0, rinc=0.
  - Any burst in flight is discarded. Words already popped are lost; no FIFO pointer recovery.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 loads remaining<=burst_len, sets mode (fixed if burst_len!=0, continuous if burst_len=0), then -> RUN. start is ignored in every other state.
  - RUN -> DRAIN when either condition holds:
    - stop=1; the pop in the stop cycle is suppressed.
    - fixed mode and the final pop occurs (remaining 1->0 on that edge).
  - DRAIN: no pops. -> DONE when occupancy==0, including the cycle the last word is accepted.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Pop rule, combinational with no path from m_ready to rinc:
  - rinc = (state==RUN) && !rempty && (occupancy<2) && !stop.
- Each pop:
  - Pushes rdata into the buffer tail.
  - Decrements remaining (fixed mode only).
  - Increments pop_count.
- Latency: a word popped at edge N is on m_data with m_valid=1 immediately after edge N. Throughput is 1 word/cycle when m_ready is held high.
- Buffer:
  - 2-entry FIFO, order preserved. m_valid = (occupancy!=0); m_data = head.
  - Transfer occurs on m_valid && m_ready.
  - Push and transfer in the same cycle leave occupancy unchanged.
  - m_data is held stable while m_valid && !m_ready.
- rempty=1 during RUN: rinc=0, state stays RUN, busy=1. No timeout; popping resumes when rempty deasserts.
- stop outside RUN, or start outside IDLE: no effect.
- m_valid stays 0 when occupancy is 0; no bubbles are inserted otherwise.

Optional Feature:
FIFO_RD_PARITY_EN:
- Defined: adds output port m_parity (1 bit) = XOR of all bits of the stored word.
  - Computed at pop time and stored alongside the data in each buffer entry.
  - Reset value 0; qualified by m_valid.
- Undefined: m_parity port and parity storage are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst: rrst_n=0 after 2 of 5 words popped -> all outputs 0 asynchronously, state IDLE. Next start with burst_len=3 pops exactly 3 words.
- Burst of 4: FIFO holds 0x11,0x22,0x33,0x44; m_ready=1; start with burst_len=4.
  - rinc high 4 consecutive cycles.
  - m_data = 0x11,0x22,0x33,0x44 on consecutive cycles.
  - done pulses once after 0x44 is accepted; pop_count=4.
- Backpressure: m_ready=0, burst_len=5 with 5 words queued.
  - Exactly 2 pops, then rinc=0; m_data held at 0x11.
  - On m_ready=1: remaining 3 words in order, total 5, done once.
- Empty stall: burst_len=4; rempty=1 after 2 words for 10 cycles.
  - rinc=0 and busy=1 throughout the stall.
  - Resumes on rempty=0; done after 4th word; pop_count=4.
- Continuous mode: burst_len=0, 8 words queued; stop asserted in the cycle the 7th pop would occur.
  - Exactly 6 pops; buffer drains; done pulses; 2 words remain in FIFO.
- Parity (FIFO_RD_PARITY_EN defined): words 0x03 and 0x07 -> m_parity = 0 then 1. start asserted while busy -> no effect on remaining or pop count.
